rat_recovery_unit: RTL and testbench
====================================

// Module: rat_recovery_unit
// PURPOSE
//  Flush-side consumer of the retired RAT. On a pipeline flush (mispredict/exception from the ROB):
//  - restores the speculative (rename) RAT from the committed mapping in one cycle;
//  - rebuilds the free list by scanning every physical register. A register is pushed unless the committed state maps it.
//  Sits between the retired RAT, the rename RAT and the free list. The frontend stalls while busy.
// PARAMETERS
//  SS         2                    superscalar width; number of free-list push lanes per cycle
//  NUM_PREGS  64                   number of physical registers (power of 2)
//  PREG_W     $clog2(NUM_PREGS)    physical register tag width
// PORTS
//  clk               in   1             clock
//  rst               in   1             asynchronous, active-low reset
//  flush_req         in   1             one-cycle flush pulse from ROB
//  retired_rat_data  in   rat_t x32     committed mapping; physical tag taken from .rd[PREG_W-1:0]
//  busy              out  1             recovery in progress (state != IDLE); frontend stall
//  spec_rat_we       out  1             one-cycle restore strobe to rename RAT
//  spec_rat_data     out  rat_t x32     restore image (= latched snapshot)
//  fl_clear          out  1             one-cycle pulse: free list empties itself (head=tail, count=0)
//  fl_push_valid     out  SS            per-lane push valid
//  fl_push_preg      out  PREG_W x SS   per-lane physical tag
//  fl_push_ready     in   1             free list accepts all valid lanes this cycle
//  recover_done      out  1             one-cycle pulse; recovery complete
// BEHAVIOUR
//  Reset (rst low, async): state=IDLE; idx=0; snapshot and in_use cleared.
//   All outputs are 0, including spec_rat_data.
//  FSM: IDLE -> RESTORE -> SCAN -> DONE -> IDLE.
//  IDLE: flush_req=1 -> latch retired_rat_data into snapshot; go to RESTORE.
//  RESTORE (exactly 1 cycle):
//   - spec_rat_we=1, spec_rat_data=snapshot, fl_clear=1.
//   - Register in_use[NUM_PREGS]: bit p set iff some arch r in 1..31 has snapshot[r].rd==p.
//   - in_use[0] is forced to 1 (x0 maps to p0). Entry 0 of the snapshot is ignored.
//   - Duplicate mappings count once.
//   - idx <= 0; go to SCAN.
//  SCAN:
//   - Lane k presents preg=idx+k, with fl_push_valid[k] = (idx+k < NUM_PREGS) && !in_use[idx+k].
//   - Advance (idx += SS) when fl_push_ready=1 or no lane is valid; otherwise hold idx and keep outputs stable.
//   - Valid/preg must not change while waiting for ready.
//   - On an advance with idx+SS >= NUM_PREGS -> DONE.
//   - Free list enqueues valid lanes in ascending lane order; sparse lanes are legal.
//  DONE (1 cycle): recover_done=1, busy still 1; next state IDLE.
//  busy=1 in RESTORE, SCAN and DONE.
//  spec_rat_we and fl_clear are asserted only in RESTORE.
//  fl_push_valid is 0 outside SCAN.
//  Latency with ready held 1: flush_req at cycle 0 -> RESTORE at cycle 1 -> SCAN for NUM_PREGS/SS cycles -> DONE.
//   For the defaults, DONE is cycle 34.
//  flush_req in any non-IDLE state: re-latch the snapshot and return to RESTORE.
//   fl_clear re-pulses and the scan restarts at idx=0. No partial pushes are retained.
//  Async reset mid-operation: pushes and strobes drop immediately; no recover_done is produced.
//  Total pushes = NUM_PREGS - popcount(in_use). No tag is pushed twice and no mapped tag is pushed.
// TESTING
//  1. All retired .rd=0, flush at c0, ready=1:
//     - spec_rat_we and fl_clear at c1, image all zero.
//     - Pushes p1..p63 in order (lane0 of c2 invalid); recover_done at c34.
//  2. x1..x31 -> p32..p62:
//     - Pushes exactly p1..p31 and p63 (32 tags).
//     - spec_rat_data[5].rd==36 at c1.
//  3. Case 1 with fl_push_ready=0 during c5..c9:
//     - idx and lane outputs frozen through c9.
//     - Same tag sequence with no loss or duplicate; recover_done at c39.
//  4. Second flush_req at c10 with a new snapshot (x1->p7):
//     - RESTORE at c11 with fl_clear again.
//     - Full rescan skips p7; recover_done at c44.
//  5. rst low at c15 during SCAN:
//     - All outputs 0 the same cycle, state IDLE.
//     - After release, no pushes until the next flush.
//  6. x0 entry=p9, x3 and x4 both ->p20:
//     - p9 is pushed; p20 not pushed; 62 pushes total.

Source files
------------

// File: rtl/rat_recovery_unit.sv
// Flush recovery: restores the rename RAT from the committed snapshot and rebuilds
// the free list by scanning all physical tags that the committed state does not map.
package rat_recovery_unit_pkg;
    localparam int unsigned RD_W = 8;

    typedef struct packed {
        logic [RD_W-1:0] rd;
    } rat_t;
endpackage

module rat_recovery_unit
    import rat_recovery_unit_pkg::*;
#(
    parameter int unsigned SS        = 2,
    parameter int unsigned NUM_PREGS = 64,
    parameter int unsigned PREG_W    = $clog2(NUM_PREGS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_req,
    input  rat_t                         retired_rat_data [32],
    output logic                         busy,
    output logic                         spec_rat_we,
    output rat_t                         spec_rat_data [32],
    output logic                         fl_clear,
    output logic [SS-1:0]                fl_push_valid,
    output logic [SS-1:0][PREG_W-1:0]    fl_push_preg,
    input  logic                         fl_push_ready,
    output logic                         recover_done
);

    localparam int unsigned NUM_ARCH = 32;
    localparam int unsigned IDX_W    = PREG_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESTORE,
        ST_SCAN,
        ST_DONE
    } state_t;

    state_t                      state;
    state_t                      state_d;
    logic [IDX_W-1:0]            idx;
    logic [IDX_W-1:0]            idx_d;
    logic [NUM_PREGS-1:0]        in_use;
    logic [NUM_PREGS-1:0]        in_use_d;
    rat_t                        snapshot [NUM_ARCH];

    logic                        busy_d;
    logic                        spec_rat_we_d;
    logic                        fl_clear_d;
    logic                        recover_done_d;
    logic [SS-1:0]               push_valid_d;
    logic [SS-1:0][PREG_W-1:0]   push_preg_d;
    logic                        advance;
    logic [IDX_W-1:0]            lane_idx;

    assign spec_rat_data = snapshot;

    // Next-state, scan index, in-use map and next output values
    always_comb begin
        state_d        = state;
        idx_d          = idx;
        in_use_d       = in_use;
        advance        = 1'b0;
        lane_idx       = '0;
        busy_d         = 1'b0;
        spec_rat_we_d  = 1'b0;
        fl_clear_d     = 1'b0;
        recover_done_d = 1'b0;
        push_valid_d   = '0;
        push_preg_d    = '0;

        unique case (state)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_RESTORE: begin
                // x0 is hardwired to p0; entry 0 of the snapshot never contributes
                in_use_d    = '0;
                in_use_d[0] = 1'b1;
                for (int r = 1; r < NUM_ARCH; r++) begin
                    in_use_d[snapshot[r].rd[PREG_W-1:0]] = 1'b1;
                end
                idx_d   = '0;
                state_d = ST_SCAN;
            end
            ST_SCAN: begin
                advance = fl_push_ready || (fl_push_valid == '0);
                if (advance) begin
                    idx_d = idx + IDX_W'(SS);
                    if (idx_d >= IDX_W'(NUM_PREGS)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new flush always wins and restarts from a fresh snapshot
        if (flush_req) begin
            state_d = ST_RESTORE;
            idx_d   = '0;
        end

        busy_d         = (state_d != ST_IDLE);
        spec_rat_we_d  = (state_d == ST_RESTORE);
        fl_clear_d     = (state_d == ST_RESTORE);
        recover_done_d = (state_d == ST_DONE);

        if (state_d == ST_SCAN) begin
            for (int k = 0; k < SS; k++) begin
                lane_idx        = idx_d + IDX_W'(k);
                push_preg_d[k]  = PREG_W'(lane_idx);
                push_valid_d[k] = (lane_idx < IDX_W'(NUM_PREGS)) &&
                                  !in_use_d[PREG_W'(lane_idx)];
            end
        end
    end

    // State, scan bookkeeping and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            idx           <= '0;
            in_use        <= '0;
            busy          <= 1'b0;
            spec_rat_we   <= 1'b0;
            fl_clear      <= 1'b0;
            recover_done  <= 1'b0;
            fl_push_valid <= '0;
            fl_push_preg  <= '0;
        end else begin
            state         <= state_d;
            idx           <= idx_d;
            in_use        <= in_use_d;
            busy          <= busy_d;
            spec_rat_we   <= spec_rat_we_d;
            fl_clear      <= fl_clear_d;
            recover_done  <= recover_done_d;
            fl_push_valid <= push_valid_d;
            fl_push_preg  <= push_preg_d;
        end
    end

    // Snapshot of the committed mapping, captured on every flush request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_ARCH; r++) begin
                snapshot[r] <= '0;
            end
        end else if (flush_req) begin
            snapshot <= retired_rat_data;
        end
    end

endmodule

// File: tb/tb_rat_recovery_unit.sv
// Directed bench for rat_recovery_unit: scoreboarded free-list pushes, restore strobes,
// backpressure hold, re-flush and mid-scan reset.
module tb_rat_recovery_unit;
    import rat_recovery_unit_pkg::*;

    localparam int SS = 2;
    localparam int NP = 64;
    localparam int PW = 6;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush_req;
    rat_t                    rrd [32];
    logic                    busy;
    logic                    spec_rat_we;
    rat_t                    spec_rat_data [32];
    logic                    fl_clear;
    logic [SS-1:0]           fl_push_valid;
    logic [SS-1:0][PW-1:0]   fl_push_preg;
    logic                    fl_push_ready;
    logic                    recover_done;

    int   errors = 0;
    int   checks = 0;
    int   q[$];
    int   q_pend[$];
    rat_t img_cur [32];
    rat_t img_a   [32];
    rat_t img_b   [32];

    rat_recovery_unit #(.SS(SS), .NUM_PREGS(NP)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush_req        (flush_req),
        .retired_rat_data (rrd),
        .busy             (busy),
        .spec_rat_we      (spec_rat_we),
        .spec_rat_data    (spec_rat_data),
        .fl_clear         (fl_clear),
        .fl_push_valid    (fl_push_valid),
        .fl_push_preg     (fl_push_preg),
        .fl_push_ready    (fl_push_ready),
        .recover_done     (recover_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic img_match();
        for (int r = 0; r < 32; r++) begin
            if (spec_rat_data[r] !== img_cur[r]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic img_zero();
        for (int r = 0; r < 32; r++) begin
            if (spec_rat_data[r] !== '0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Drive a flush and queue the tags the free list must receive for this image
    task automatic do_flush(input rat_t img [32]);
        logic [NP-1:0] used;
        rrd       = img;
        img_cur   = img;
        flush_req = 1'b1;
        used      = '0;
        used[0]   = 1'b1;
        for (int r = 1; r < 32; r++) used[img[r].rd[PW-1:0]] = 1'b1;
        q_pend.delete();
        for (int p = 0; p < NP; p++) if (!used[p]) q_pend.push_back(p);
    endtask

    task automatic clear_img(output rat_t img [32]);
        for (int r = 0; r < 32; r++) img[r] = '0;
    endtask

    // Called at a falling edge; that cycle is c0 of the flush
    task automatic run(input string name, input int lo_s, input int lo_e,
                       input int reflush_at, input int rst_at,
                       input int exp_done, input int exp_npush);
        int                    npush;
        int                    restore_c;
        logic                  prev_ready;
        logic [SS-1:0]         prev_valid;
        logic [SS-1:0][PW-1:0] prev_preg;
        logic                  done;
        npush      = 0;
        restore_c  = -10;
        prev_ready = 1'b1;
        prev_valid = '0;
        prev_preg  = '0;
        done       = 1'b0;
        do_flush(img_a);
        for (int c = 1; c <= 70 && !done; c++) begin
            @(negedge clk);
            flush_req     = 1'b0;
            fl_push_ready = !(c >= lo_s && c <= lo_e);
            if (c == rst_at) begin
                rst = 1'b0;
                #1;
                chk({name, " rst busy"}, 32'(busy), 0);
                chk({name, " rst valid"}, 32'(fl_push_valid), 0);
                chk({name, " rst preg"}, 32'(fl_push_preg), 0);
                chk({name, " rst we/clear/done"}, {29'd0, spec_rat_we, fl_clear, recover_done}, 0);
                chk({name, " rst image"}, 32'(img_zero()), 1);
                @(negedge clk);
                rst = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk({name, " post-rst idle"}, {28'd0, busy, recover_done, fl_push_valid}, 0);
                end
                return;
            end
            if (c == reflush_at) do_flush(img_b);
            if (fl_clear) begin
                restore_c = c;
                q         = q_pend;
                npush     = 0;
                chk({name, " restore we"}, 32'(spec_rat_we), 1);
                chk({name, " restore busy"}, 32'(busy), 1);
                chk({name, " restore no push"}, 32'(fl_push_valid), 0);
                chk({name, " restore image"}, 32'(img_match()), 1);
            end else begin
                chk($sformatf("%s we c%0d", name, c), 32'(spec_rat_we), 0);
            end
            if (c == restore_c + 1)
                chk({name, " first lane0 invalid"}, 32'(fl_push_valid[0]), 0);
            if (!prev_ready && prev_valid != '0) begin
                chk($sformatf("%s hold valid c%0d", name, c), 32'(fl_push_valid), 32'(prev_valid));
                chk($sformatf("%s hold preg c%0d", name, c), 32'(fl_push_preg), 32'(prev_preg));
            end
            for (int k = 0; k < SS; k++) begin
                if (fl_push_valid[k] && fl_push_ready) begin
                    if (q.size() == 0) chk($sformatf("%s extra push c%0d", name, c), 32'(fl_push_preg[k]), 32'hFFFF);
                    else chk($sformatf("%s push c%0d lane%0d", name, c, k), 32'(fl_push_preg[k]), 32'(q.pop_front()));
                    npush++;
                end
            end
            prev_ready = fl_push_ready;
            prev_valid = fl_push_valid;
            prev_preg  = fl_push_preg;
            if (recover_done) begin
                chk({name, " done cycle"}, 32'(c), 32'(exp_done));
                chk({name, " done busy"}, 32'(busy), 1);
                chk({name, " done no push"}, 32'(fl_push_valid), 0);
                chk({name, " push count"}, 32'(npush), 32'(exp_npush));
                chk({name, " leftover tags"}, 32'(q.size()), 0);
                done = 1'b1;
            end
        end
        chk({name, " done seen"}, 32'(done), 1);
        fl_push_ready = 1'b1;
        @(negedge clk);
        chk({name, " idle after"}, {30'd0, busy, recover_done}, 0);
    endtask

    initial begin
        rst           = 1'b0;
        flush_req     = 1'b0;
        fl_push_ready = 1'b1;
        clear_img(img_a);
        clear_img(img_b);
        rrd     = img_a;
        img_cur = img_a;
        #1;
        chk("reset busy", 32'(busy), 0);
        chk("reset strobes", {29'd0, spec_rat_we, fl_clear, recover_done}, 0);
        chk("reset push", 32'(fl_push_valid), 0);
        chk("reset image", 32'(img_zero()), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        clear_img(img_a);
        run("t1_zero", -1, -1, -1, -1, 34, 63);

        for (int r = 1; r < 32; r++) img_a[r].rd = 8'(31 + r);
        run("t2_high", -1, -1, -1, -1, 34, 32);

        clear_img(img_a);
        run("t3_stall", 5, 9, -1, -1, 39, 63);

        img_b[1].rd = 8'd7;
        run("t4_reflush", -1, -1, 10, -1, 44, 62);

        run("t5_reset", -1, -1, -1, 15, -1, 0);

        clear_img(img_a);
        img_a[0].rd = 8'd9;
        img_a[3].rd = 8'd20;
        img_a[4].rd = 8'd20;
        run("t6_dup", -1, -1, -1, -1, 34, 62);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
